// File: rtl/lighting_actuator.sv
// Lighting actuator: latches a lamp/shade target over valid/ready and walks the outputs toward it.
// Config macro INRUSH_STAGGER_EN: when defined, lamps toggle one per STEP_CYCLES; otherwise they load at accept.
module lighting_actuator #(
  parameter int STEP_CYCLES  = 4,
  parameter int SHADE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_lights,
  input  logic [3:0]  cmd_shade,
  output logic [15:0] lamp_out,
  output logic [3:0]  shade_pos,
  output logic        motor_up,
  output logic        motor_dn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  tgt_s;
  logic [7:0]  shade_cnt;
  logic        accept;
  logic        lamps_match;
  logic        shade_match;
  logic        shade_wrap;

  assign accept      = (state == IDLE) && cmd_valid;
  assign shade_match = (shade_pos == tgt_s);
  assign shade_wrap  = (shade_cnt == 8'(SHADE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = RUN;
      RUN:     if (lamps_match && shade_match) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Motor drive is decoded from registered state only, so up/down are mutually exclusive.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    motor_up  = (state == RUN) && (shade_pos < tgt_s);
    motor_dn  = (state == RUN) && (shade_pos > tgt_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_s     <= 4'd0;
      shade_cnt <= 8'd0;
      shade_pos <= 4'd0;
    end else if (accept) begin
      tgt_s     <= cmd_shade;
      shade_cnt <= 8'd0;
    end else if (motor_up || motor_dn) begin
      if (shade_wrap) begin
        shade_cnt <= 8'd0;
        shade_pos <= motor_up ? shade_pos + 4'd1 : shade_pos - 4'd1;
      end else begin
        shade_cnt <= shade_cnt + 8'd1;
      end
    end
  end

`ifdef INRUSH_STAGGER_EN
  logic [15:0] tgt_l;
  logic [15:0] lamp_diff;
  logic [15:0] lamp_pick;
  logic [7:0]  step_cnt;

  // Isolate the lowest mismatched lamp; on and off transitions are treated the same.
  assign lamp_diff   = lamp_out ^ tgt_l;
  assign lamp_pick   = lamp_diff & (~lamp_diff + 16'd1);
  assign lamps_match = (lamp_diff == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_l    <= 16'd0;
      step_cnt <= 8'd0;
      lamp_out <= 16'd0;
    end else if (accept) begin
      tgt_l    <= cmd_lights;
      step_cnt <= 8'd0;
    end else if (state == RUN) begin
      if (step_cnt == 8'(STEP_CYCLES - 1)) begin
        step_cnt <= 8'd0;
        lamp_out <= lamp_out ^ lamp_pick;
      end else begin
        step_cnt <= step_cnt + 8'd1;
      end
    end
  end
`else
  assign lamps_match = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_out <= 16'd0;
    end else if (accept) begin
      lamp_out <= cmd_lights;
    end
  end
`endif

endmodule

// File: tb/tb_lighting_actuator.sv
// Directed bench for lighting_actuator; lamp expectations follow whichever INRUSH_STAGGER_EN build is compiled.
module tb_lighting_actuator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_lights = 16'd0;
  logic [3:0]  cmd_shade = 4'd0;
  logic [15:0] lamp_out;
  logic [3:0]  shade_pos;
  logic        motor_up;
  logic        motor_dn;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  lighting_actuator #(.STEP_CYCLES(4), .SHADE_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_lights(cmd_lights),
    .cmd_shade (cmd_shade),
    .lamp_out  (lamp_out),
    .shade_pos (shade_pos),
    .motor_up  (motor_up),
    .motor_dn  (motor_dn),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a command at a negedge; returns at the negedge after the accept edge (edge 0).
  task automatic accept_cmd(input logic [15:0] lights, input logic [3:0] shade);
    int n = 0;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check("accept_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_lights = lights;
    cmd_shade  = shade;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!cmd_ready && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lamp"}, {16'd0, lamp_out}, 32'h0000);
    check({tag, "_shade"}, {28'd0, shade_pos}, 32'd0);
    check({tag, "_motors"}, {30'd0, motor_up, motor_dn}, 32'd0);
    check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  logic [15:0] lamp_tbl [0:8];
  int          ready_cnt;

  initial begin
    lamp_tbl[0] = 16'h00F0; lamp_tbl[1] = 16'h00E0; lamp_tbl[2] = 16'h00C0;
    lamp_tbl[3] = 16'h0080; lamp_tbl[4] = 16'h0000; lamp_tbl[5] = 16'h0100;
    lamp_tbl[6] = 16'h0300; lamp_tbl[7] = 16'h0700; lamp_tbl[8] = 16'h0F00;

    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    tick();
    check_reset_vals("rst_rel");

    // Shade up 0 -> 5 with lamps unchanged: moves at edges 8..40, done after edge 41.
    accept_cmd(16'h0000, 4'd5);
    check("up_busy0", {30'd0, busy, cmd_ready}, 32'b10);
    check("up_motor0", {30'd0, motor_up, motor_dn}, 32'b10);
    for (int e = 1; e <= 42; e++) begin
      tick();
      if (e <= 40) check($sformatf("up_pos_e%0d", e), {28'd0, shade_pos}, e / 8);
      check($sformatf("up_mup_e%0d", e), {31'd0, motor_up}, (e < 40) ? 32'd1 : 32'd0);
      check($sformatf("up_mdn_e%0d", e), {31'd0, motor_dn}, 32'd0);
      if (e == 40) check("up_done40", {31'd0, done}, 32'd0);
      if (e == 41) check("up_done41", {31'd0, done}, 32'd1);
      if (e == 42) check("up_idle42", {30'd0, done, cmd_ready}, 32'b01);
    end

`ifdef INRUSH_STAGGER_EN
    // Full turn-on: bit i sets at edge 4(i+1); done after edge 65.
    accept_cmd(16'hFFFF, 4'd5);
    for (int e = 1; e <= 66; e++) begin
      logic [31:0] exp_l;
      tick();
      exp_l = (32'd1 << ((e > 64 ? 64 : e) / 4)) - 32'd1;
      if (e <= 64) check($sformatf("on_lamp_e%0d", e), {16'd0, lamp_out}, {16'd0, exp_l[15:0]});
      if (e == 64) check("on_done64", {31'd0, done}, 32'd0);
      if (e == 65) check("on_done65", {31'd0, done}, 32'd1);
      if (e == 66) check("on_idle66", {30'd0, done, cmd_ready}, 32'b01);
    end
`else
    // Unstaggered: lamps load at accept, shade already at target so done after edge 1.
    accept_cmd(16'hA5A5, 4'd5);
    check("ns_lamp0", {16'd0, lamp_out}, 32'hA5A5);
    tick();
    check("ns_done1", {31'd0, done}, 32'd1);
    tick();
    check("ns_idle2", {30'd0, done, cmd_ready}, 32'b01);
`endif

    // Set up lamps=0x00F0, shade=9 for the mixed command.
    accept_cmd(16'h00F0, 4'd9);
    wait_idle(300);
    check("mix_setup", {12'd0, shade_pos, lamp_out}, {12'd0, 4'd9, 16'h00F0});

    // Mixed: lamps 0x00F0 -> 0x0F00 lowest bit first, shade 9 -> 3 by edge 48, done after edge 49.
    accept_cmd(16'h0F00, 4'd3);
    for (int e = 1; e <= 50; e++) begin
      tick();
`ifdef INRUSH_STAGGER_EN
      if (e % 4 == 0 && e <= 32) check($sformatf("mix_lamp_e%0d", e), {16'd0, lamp_out}, {16'd0, lamp_tbl[e / 4]});
`else
      if (e == 1) check("mix_lamp_e1", {16'd0, lamp_out}, 32'h0F00);
`endif
      if (e % 8 == 0 && e <= 48) check($sformatf("mix_pos_e%0d", e), {28'd0, shade_pos}, 9 - e / 8);
      check($sformatf("mix_mdn_e%0d", e), {30'd0, motor_dn, motor_up}, (e < 48) ? 32'b10 : 32'b00);
      if (e == 48) check("mix_done48", {31'd0, done}, 32'd0);
      if (e == 49) check("mix_done49", {31'd0, done}, 32'd1);
      if (e == 50) check("mix_idle50", {30'd0, done, cmd_ready}, 32'b01);
    end

    // No-op: target equals current state.
    accept_cmd(16'h0F00, 4'd3);
    check("noop_e0", {29'd0, busy, cmd_ready, done}, 32'b100);
    tick();
    check("noop_e1", {29'd0, busy, cmd_ready, done}, 32'b101);
    tick();
    check("noop_e2", {29'd0, busy, cmd_ready, done}, 32'b010);

    // Long command (shade 3 -> 15, done after edge 97) while a different target is held valid.
    accept_cmd(16'hFFFF, 4'd15);
    cmd_lights = 16'h1234;
    cmd_shade  = 4'd0;
    cmd_valid  = 1'b1;
    ready_cnt  = 0;
    while (!cmd_ready && ready_cnt < 200) begin
      tick();
      ready_cnt++;
    end
    check("busy_ready_edge", ready_cnt, 32'd98);
    check("busy_ignored", {12'd0, shade_pos, lamp_out}, {12'd0, 4'd15, 16'hFFFF});
    tick();
    cmd_valid = 1'b0;
    check("busy_accepted", {30'd0, busy, cmd_ready}, 32'b10);
    wait_idle(400);
    check("busy_second", {12'd0, shade_pos, lamp_out}, {12'd0, 4'd0, 16'h1234});

    // Reset at edge 20 of a command from 0x1234/0 toward 0xFFFF/15.
    accept_cmd(16'hFFFF, 4'd15);
    for (int e = 1; e <= 20; e++) tick();
    check("rmid_pre", {29'd0, busy, motor_up, done}, 32'b110);
    check("rmid_pos", {28'd0, shade_pos}, 32'd2);
`ifdef INRUSH_STAGGER_EN
    check("rmid_lamp", {16'd0, lamp_out}, 32'h12FF);
`endif
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rmid_async");
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rmid_nodone%0d", c), {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_reset_vals("rmid_rel");
    tick();
    check("rmid_nodone_after", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lighting_actuator.md
# lighting_actuator

Actuator-side sequencer for the smart-home lighting path. It accepts a target lamp pattern and window-shade level from the lighting decision logic over a valid/ready handshake and drives the physical lamp enables and shade motor toward that target. Lamps are switched one at a time to limit inrush current, and the shade moves one level per motor period. It reports completion with a one-cycle pulse.

## Interface
- `STEP_CYCLES`, default 4: clock cycles between successive lamp toggles; legal range 1..256.
- `SHADE_CYCLES`, default 8: clock cycles per one-level shade move; legal range 1..256.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset; **asynchronous and active-low**.
- `cmd_valid` in 1: a new target is presented.
- `cmd_ready` out 1: the block can accept a target; high only in IDLE.
- `cmd_lights` in 16: target lamp pattern; bit i is lamp i, 1 = on.
- `cmd_shade` in 4: target shade level, 0..15.
- `lamp_out` out 16: current lamp enables (registered).
- `shade_pos` out 4: current shade level (registered).
- `motor_up` out 1: drive shade toward higher level.
- `motor_dn` out 1: drive shade toward lower level.
- `busy` out 1: a command is in progress (state is not IDLE).
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:** `cmd_ready`=1. On an edge with `cmd_valid`=1:
  - latch `cmd_lights` into tgt_l and `cmd_shade` into tgt_s;
  - clear step_cnt and shade_cnt;
  - go to RUN.
- **RUN, lamp sequencer:**
  - step_cnt increments every edge.
  - When step_cnt==STEP_CYCLES-1, step_cnt wraps to 0. If `lamp_out`≠tgt_l, toggle the lowest-index mismatched bit (turn-on and turn-off are treated alike).
  - At most one lamp bit changes per edge.
- **RUN, shade sequencer** (runs in parallel with the lamp sequencer):
  - `motor_up` = RUN && `shade_pos`<tgt_s.
  - `motor_dn` = RUN && `shade_pos`>tgt_s.
  - Both are decoded from registered state; they are never high together.
  - shade_cnt increments each edge while either motor output is high.
  - When shade_cnt==SHADE_CYCLES-1, shade_cnt wraps to 0 and `shade_pos` moves ±1 toward tgt_s.
- **RUN → DONE:** on an edge where, at the start of the cycle, `lamp_out`==tgt_l and `shade_pos`==tgt_s.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- Counter widths are 8 bits. Parameters outside the legal range are unsupported.
- `shade_pos` never wraps past 0 or 15, because tgt_s lies in 0..15.
- `cmd_valid` while not in IDLE is ignored. The command is not queued; the source holds it until `cmd_ready`.
- `cmd_lights`/`cmd_shade` changing during RUN has no effect, because the targets are latched.

## Timing
- Reset values:
  - `lamp_out`=0x0000, `shade_pos`=0
  - `motor_up`=`motor_dn`=0
  - `busy`=0, `done`=0
  - `cmd_ready`=1 (IDLE)
  - tgt_l, tgt_s and both counters 0
- Reset asserted mid-command returns to these values immediately. The in-flight target is discarded, with no `done`.
- **Accept:** takes effect at the edge where `cmd_valid`&&`cmd_ready`. `busy` rises and `cmd_ready` falls in the following cycle.
- **Lamps:** the k-th lamp toggle occurs at the k·STEP_CYCLES-th edge after accept.
- **Shade:** the m-th level move occurs at the m·SHADE_CYCLES-th edge after accept.
- **Completion:** with the last change at edge E after accept:
  - RUN→DONE at edge E+1;
  - `done` is high in the cycle after edge E+1;
  - IDLE and `cmd_ready`=1 follow edge E+2.
- **No-op command** (targets already equal current): RUN→DONE at edge 1 after accept, IDLE at edge 2. `cmd_ready` is low for 2 cycles.
- Back-to-back: the earliest next accept is the first IDLE edge.

## Configuration
- `INRUSH_STAGGER_EN` defined (the default build): lamp sequencing is staggered as described in Operation.
- `INRUSH_STAGGER_EN` undefined:
  - `lamp_out` loads `cmd_lights` at the accept edge;
  - step_cnt is removed;
  - the lamp-match condition is true throughout RUN, so completion depends on the shade only.
- Shade behaviour and the handshake are identical in both builds.

## Test plan
- **Full turn-on:** reset, then accept lights=0xFFFF, shade=0, STEP_CYCLES=4.
  - Bit i sets at edge 4(i+1).
  - `lamp_out`=0xFFFF at edge 64.
  - `done` is high in the cycle after edge 65, then `cmd_ready`=1.
- **Shade up:** accept lights=0x0000, shade=5, SHADE_CYCLES=8.
  - `motor_up`=1 from accept until edge 40.
  - `shade_pos` steps 1..5 at edges 8, 16, 24, 32, 40.
  - `motor_dn` is never high.
- **Mixed command:** from lamps=0x00F0, shade=9, accept lights=0x0F00, shade=3.
  - Lamp order: bits 4–7 clear first, then bits 8–11 set.
  - `motor_dn` is high and `shade_pos` reaches 3 after 48 edges.
  - `done` fires after the later of the two finishes.
- **No-op and busy:** accept a target equal to the current state; `done` fires one cycle after RUN begins.
  - During a long command, hold `cmd_valid`=1 with a different target; it is ignored until `cmd_ready`, then accepted.
- **Reset mid-run:** assert `rst_n`=0 at edge 20 of a 0xFFFF command.
  - All outputs return to reset values asynchronously; no `done`.
  - After release, `cmd_ready`=1.
- **Build without INRUSH_STAGGER_EN:** accept lights=0xA5A5, shade=0.
  - `lamp_out`=0xA5A5 in the cycle after accept.
  - `done` is high in the cycle after edge 1.
